conv_feeder: RTL and testbench
==============================

CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameter WIDTH, default 64, bit width of one sample and one kernel element.
REQ-002 Parameter LEN, default 4, number of taps per window and per kernel.
REQ-003 Port clk, input, 1, the single clock; all state is updated on the rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port kernel_in, input, LEN*WIDTH, kernel coefficients; element i is bits [i*WIDTH +: WIDTH].
REQ-006 Port kernel_load, input, 1, strobe that captures kernel_in.
REQ-007 Port flush, input, 1, clears the sample window.
REQ-008 Port sample_in, sample_valid, sample_ready: WIDTH, input, input, output; the upstream scalar sample stream.
REQ-009 Port conv_kernel, conv_data: output, LEN*WIDTH each; kernel and window vectors driven to the convolution operator.
REQ-010 Port conv_valid, output, 1 and conv_ready, input, 1: the issue handshake toward the operator.
REQ-011 Port conv_result, input, 2*WIDTH and conv_result_valid, input, 1: the result returned by the operator.
REQ-012 Port conv_result_ready, output, 1: result acceptance toward the operator.
REQ-013 Port result_out, output, 2*WIDTH; result_valid, output, 1; result_ready, input, 1: the downstream result stream.
REQ-014 Port windows_issued, output, 16, count of completed issue handshakes; wraps from 0xFFFF to 0.

Function
REQ-015 The state machine SHALL have four states: FILL, ISSUE, WAIT and OUT; it SHALL hold at most one window outstanding.
REQ-016 sample_ready SHALL equal (state==FILL && !flush); a sample is accepted when sample_valid && sample_ready.
REQ-017 On acceptance the window SHALL shift: data[i] <= data[i+1] for i<LEN-1, and data[LEN-1] <= sample_in (index 0 holds the oldest sample).
REQ-018 fill_cnt SHALL increment on each acceptance and saturate at LEN.
REQ-019 FILL->ISSUE SHALL occur on the edge where a sample is accepted and the post-increment fill_cnt equals LEN; conv_valid SHALL rise the following cycle.
REQ-020 conv_valid SHALL be 1 exactly in ISSUE; ISSUE->WAIT SHALL occur on conv_valid && conv_ready; windows_issued SHALL increment on that edge.
REQ-021 conv_data and conv_kernel SHALL remain constant from entry to ISSUE until the return to FILL.
REQ-022 conv_result_ready SHALL be 1 exactly in WAIT.
REQ-023 On conv_result_valid in WAIT, conv_result SHALL be registered unmodified into result_out and the state SHALL go to OUT; conv_result_valid outside WAIT SHALL be ignored.
REQ-024 result_valid SHALL be 1 exactly in OUT; result_out SHALL be stable while result_valid && !result_ready.
REQ-025 OUT->FILL SHALL occur on result_ready; fill_cnt SHALL remain LEN, so each further accepted sample issues a new window.
REQ-026 kernel_load SHALL be honoured only in FILL; it is ignored in other states.
REQ-027 kernel_load and a sample acceptance in the same cycle SHALL both take effect; a window issued by that acceptance SHALL carry the new kernel.
REQ-028 flush SHALL be honoured only in FILL and SHALL zero the window and fill_cnt.
REQ-029 flush SHALL take priority over sample_valid, since sample_ready is 0 while flush is high.
REQ-030 flush with kernel_load in the same cycle SHALL load the kernel; flush SHALL NOT clear the kernel.

Reset
REQ-031 While rst is high, state SHALL be FILL and window, kernel, fill_cnt, result_out and windows_issued SHALL be 0.
REQ-032 While rst is high, conv_valid, conv_result_ready and result_valid SHALL be 0; sample_ready SHALL be !flush.
REQ-033 Reset asserted in any state, including ISSUE or WAIT, SHALL abandon the outstanding window; a late conv_result_valid after reset SHALL be ignored.

Verification (WIDTH=64, LEN=4)
REQ-034 Reset check: assert rst mid-cycle -> all registered outputs 0 immediately, conv_valid=0, sample_ready=1.
REQ-035 Fill and issue: kernel_load with {1,2,3,4}, then samples 1,2,3 -> conv_valid stays 0; sample 4 -> next cycle conv_valid=1, conv_data={1,2,3,4}, conv_kernel={1,2,3,4}.
REQ-036 Issue backpressure: conv_ready low 5 cycles -> conv_valid, conv_data and conv_kernel stable, sample_ready=0; then conv_ready=1 -> WAIT and windows_issued=1.
REQ-037 Result backpressure: return 30 -> result_out=30, result_valid=1; hold result_ready low 3 cycles -> output held; release it, then send sample 5 -> next cycle conv_data={2,3,4,5}.
REQ-038 Flush: after 2 samples, flush -> fill_cnt=0 and window=0; then 4 samples 7,8,9,10 are required before conv_valid, with conv_data={7,8,9,10}.
REQ-039 Reset mid-WAIT, then conv_result_valid one cycle later -> result_valid stays 0, state FILL, windows_issued=0.

Source files
------------

// File: rtl/conv_feeder.sv
// Convolution feeder: gathers a sliding window of scalar samples and a coefficient
// kernel, issues one window at a time to the operator and forwards its result downstream.
module conv_feeder #(
  parameter int WIDTH = 64,
  parameter int LEN   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN*WIDTH-1:0] kernel_in,
  input  logic                 kernel_load,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [LEN*WIDTH-1:0] conv_kernel,
  output logic [LEN*WIDTH-1:0] conv_data,
  output logic                 conv_valid,
  input  logic                 conv_ready,
  input  logic [2*WIDTH-1:0]   conv_result,
  input  logic                 conv_result_valid,
  output logic                 conv_result_ready,
  output logic [2*WIDTH-1:0]   result_out,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [15:0]          windows_issued
);

  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_window [LEN];
  logic [WIDTH-1:0]   r_kernel [LEN];
  logic [CW-1:0]      r_fill_cnt;
  logic [CW-1:0]      w_fill_cnt_next;
  logic [2*WIDTH-1:0] r_result;
  logic [15:0]        r_windows_issued;
  logic               w_in_fill;
  logic               w_accept;
  logic               w_flush;
  logic               w_kernel_load;

  assign w_in_fill     = (r_state == S_FILL);
  assign sample_ready  = w_in_fill && !flush;
  assign w_accept      = sample_valid && sample_ready;
  assign w_flush       = w_in_fill && flush;
  assign w_kernel_load = w_in_fill && kernel_load;

  // Count saturates at LEN so that every later sample completes a fresh window.
  always_comb begin
    w_fill_cnt_next = r_fill_cnt;
    if (w_flush) begin
      w_fill_cnt_next = '0;
    end else if (w_accept && (r_fill_cnt != CW'(LEN))) begin
      w_fill_cnt_next = r_fill_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    conv_valid        = 1'b0;
    conv_result_ready = 1'b0;
    result_valid      = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_accept && (w_fill_cnt_next == CW'(LEN))) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        conv_valid = 1'b1;
        if (conv_ready) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        conv_result_ready = 1'b1;
        if (conv_result_valid) w_state_next = S_OUT;
      end
      S_OUT: begin
        result_valid = 1'b1;
        if (result_ready) w_state_next = S_FILL;
      end
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_FILL;
      r_fill_cnt       <= '0;
      r_result         <= '0;
      r_windows_issued <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fill_cnt <= w_fill_cnt_next;
      if ((r_state == S_WAIT) && conv_result_valid) r_result <= conv_result;
      if ((r_state == S_ISSUE) && conv_ready) r_windows_issued <= r_windows_issued + 16'd1;
    end
  end

  // Index 0 holds the oldest sample; new samples enter at LEN-1.
  genvar gi;
  generate
    for (gi = 0; gi < LEN; gi++) begin : g_tap
      logic [WIDTH-1:0] w_shift_in;
      if (gi == LEN - 1) begin : g_last
        assign w_shift_in = sample_in;
      end else begin : g_mid
        assign w_shift_in = r_window[gi+1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_window[gi] <= '0;
          r_kernel[gi] <= '0;
        end else begin
          if (w_flush) begin
            r_window[gi] <= '0;
          end else if (w_accept) begin
            r_window[gi] <= w_shift_in;
          end
          if (w_kernel_load) r_kernel[gi] <= kernel_in[gi*WIDTH +: WIDTH];
        end
      end

      assign conv_data[gi*WIDTH +: WIDTH]   = r_window[gi];
      assign conv_kernel[gi*WIDTH +: WIDTH] = r_kernel[gi];
    end
  endgenerate

  assign result_out     = r_result;
  assign windows_issued = r_windows_issued;

endmodule

// File: tb/tb_conv_feeder.sv
// Bench for conv_feeder: directed vector table, reset corner sequences, then
// randomized traffic compared against a queue-based reference model.
module tb_conv_feeder;
  localparam int W  = 64;
  localparam int L  = 4;
  localparam int DW = L * W;
  localparam int NRND = 2500;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   kernel_in;
  logic            kernel_load;
  logic            flush;
  logic [W-1:0]    sample_in;
  logic            sample_valid;
  logic            sample_ready;
  logic [DW-1:0]   conv_kernel;
  logic [DW-1:0]   conv_data;
  logic            conv_valid;
  logic            conv_ready;
  logic [2*W-1:0]  conv_result;
  logic            conv_result_valid;
  logic            conv_result_ready;
  logic [2*W-1:0]  result_out;
  logic            result_valid;
  logic            result_ready;
  logic [15:0]     windows_issued;

  conv_feeder #(.WIDTH(W), .LEN(L)) dut (
    .clk(clk), .rst(rst),
    .kernel_in(kernel_in), .kernel_load(kernel_load), .flush(flush),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .conv_kernel(conv_kernel), .conv_data(conv_data),
    .conv_valid(conv_valid), .conv_ready(conv_ready),
    .conv_result(conv_result), .conv_result_valid(conv_result_valid),
    .conv_result_ready(conv_result_ready),
    .result_out(result_out), .result_valid(result_valid), .result_ready(result_ready),
    .windows_issued(windows_issued)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    logic [DW-1:0] v;
    v = {W'(d), W'(c), W'(b), W'(a)};
    return v;
  endfunction

  // ctl = {kernel_load, flush, sample_valid, conv_ready, conv_result_valid, result_ready}
  // exp = {sample_ready, conv_valid, conv_result_ready, result_valid}
  typedef struct {
    logic [5:0]    ctl;
    logic [DW-1:0] kin;
    int unsigned   s;
    int unsigned   r;
    logic [3:0]    exp;
    int unsigned   wi;
    logic [DW-1:0] data;
    logic [DW-1:0] kern;
    int unsigned   res;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] ctl, input logic [DW-1:0] kin, input int unsigned s,
                     input int unsigned r, input logic [3:0] exp, input int unsigned wi,
                     input logic [DW-1:0] data, input logic [DW-1:0] kern, input int unsigned res);
    vec_t v;
    v.ctl = ctl; v.kin = kin; v.s = s; v.r = r; v.exp = exp;
    v.wi = wi; v.data = data; v.kern = kern; v.res = res;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    kernel_in = '0; kernel_load = 1'b0; flush = 1'b0;
    sample_in = '0; sample_valid = 1'b0; conv_ready = 1'b0;
    conv_result = '0; conv_result_valid = 1'b0; result_ready = 1'b0;
  endtask

  // Reference model: window as a queue of the last L samples, phase 0..3 = fill/issue/wait/out.
  logic [W-1:0]   m_win[$];
  logic [W-1:0]   m_kern[L];
  int             m_cnt;
  int             m_ph;
  logic [2*W-1:0] m_res;
  int unsigned    m_wi;

  task automatic model_reset();
    m_win.delete();
    repeat (L) m_win.push_back('0);
    for (int i = 0; i < L; i++) m_kern[i] = '0;
    m_cnt = 0; m_ph = 0; m_res = '0; m_wi = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      case (m_ph)
        0: begin
          if (kernel_load)
            for (int i = 0; i < L; i++) m_kern[i] = kernel_in[i*W +: W];
          if (flush) begin
            m_win.delete();
            repeat (L) m_win.push_back('0);
            m_cnt = 0;
          end else if (sample_valid) begin
            void'(m_win.pop_front());
            m_win.push_back(sample_in);
            if (m_cnt < L) m_cnt++;
            if (m_cnt == L) m_ph = 1;
          end
        end
        1: if (conv_ready) begin m_wi = (m_wi + 1) % 65536; m_ph = 2; end
        2: if (conv_result_valid) begin m_res = conv_result; m_ph = 3; end
        default: if (result_ready) m_ph = 0;
      endcase
    end
  endtask

  task automatic cmp_model(input int cyc);
    logic [DW-1:0] d;
    logic [DW-1:0] k;
    for (int i = 0; i < L; i++) begin
      d[i*W +: W] = m_win[i];
      k[i*W +: W] = m_kern[i];
    end
    check($sformatf("rnd%0d sample_ready", cyc), DW'(sample_ready), DW'((m_ph == 0) && !flush));
    check($sformatf("rnd%0d conv_valid", cyc), DW'(conv_valid), DW'(m_ph == 1));
    check($sformatf("rnd%0d conv_result_ready", cyc), DW'(conv_result_ready), DW'(m_ph == 2));
    check($sformatf("rnd%0d result_valid", cyc), DW'(result_valid), DW'(m_ph == 3));
    check($sformatf("rnd%0d windows_issued", cyc), DW'(windows_issued), DW'(m_wi));
    check($sformatf("rnd%0d conv_data", cyc), conv_data, d);
    check($sformatf("rnd%0d conv_kernel", cyc), conv_kernel, k);
    check($sformatf("rnd%0d result_out", cyc), DW'(result_out), DW'(m_res));
  endtask

  initial begin
    logic [DW-1:0] kk, k2, jj, zz;
    kk = pk(1, 2, 3, 4);
    k2 = pk(9, 8, 7, 6);
    jj = pk(5, 5, 5, 5);
    zz = '0;

    // Power-up reset: everything zero, sample_ready follows !flush.
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst conv_valid", DW'(conv_valid), DW'(0));
    check("rst sample_ready", DW'(sample_ready), DW'(1));
    check("rst windows_issued", DW'(windows_issued), DW'(0));
    check("rst result_valid", DW'(result_valid), DW'(0));
    flush = 1'b1;
    #1;
    check("rst flush sample_ready", DW'(sample_ready), DW'(0));
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    add(6'b100000, kk, 0, 0, 4'b1000, 0, zz, kk, 0);
    add(6'b001000, zz, 1, 0, 4'b1000, 0, pk(0, 0, 0, 1), kk, 0);
    add(6'b001000, zz, 2, 0, 4'b1000, 0, pk(0, 0, 1, 2), kk, 0);
    add(6'b001000, zz, 3, 0, 4'b1000, 0, pk(0, 1, 2, 3), kk, 0);
    add(6'b001000, zz, 4, 0, 4'b0100, 0, pk(1, 2, 3, 4), kk, 0);
    for (int i = 0; i < 5; i++)
      add(6'b101011, jj, 99, 55, 4'b0100, 0, pk(1, 2, 3, 4), kk, 0);
    add(6'b000100, zz, 0, 0, 4'b0010, 1, pk(1, 2, 3, 4), kk, 0);
    add(6'b000010, zz, 0, 30, 4'b0001, 1, pk(1, 2, 3, 4), kk, 30);
    for (int i = 0; i < 3; i++)
      add(6'b101110, jj, 98, 77, 4'b0001, 1, pk(1, 2, 3, 4), kk, 30);
    add(6'b000001, zz, 0, 0, 4'b1000, 1, pk(1, 2, 3, 4), kk, 30);
    add(6'b001000, zz, 5, 0, 4'b0100, 1, pk(2, 3, 4, 5), kk, 30);
    add(6'b000100, zz, 0, 0, 4'b0010, 2, pk(2, 3, 4, 5), kk, 30);
    add(6'b000010, zz, 0, 31, 4'b0001, 2, pk(2, 3, 4, 5), kk, 31);
    add(6'b000001, zz, 0, 0, 4'b1000, 2, pk(2, 3, 4, 5), kk, 31);
    add(6'b010000, zz, 0, 0, 4'b0000, 2, zz, kk, 31);
    add(6'b001000, zz, 11, 0, 4'b1000, 2, pk(0, 0, 0, 11), kk, 31);
    add(6'b001000, zz, 12, 0, 4'b1000, 2, pk(0, 0, 11, 12), kk, 31);
    add(6'b111000, k2, 55, 0, 4'b0000, 2, zz, k2, 31);
    add(6'b001000, zz, 7, 0, 4'b1000, 2, pk(0, 0, 0, 7), k2, 31);
    add(6'b001000, zz, 8, 0, 4'b1000, 2, pk(0, 0, 7, 8), k2, 31);
    add(6'b001000, zz, 9, 0, 4'b1000, 2, pk(0, 7, 8, 9), k2, 31);
    add(6'b001000, zz, 10, 0, 4'b0100, 2, pk(7, 8, 9, 10), k2, 31);
    add(6'b000100, zz, 0, 0, 4'b0010, 3, pk(7, 8, 9, 10), k2, 31);

    foreach (tbl[i]) begin
      {kernel_load, flush, sample_valid, conv_ready, conv_result_valid, result_ready} = tbl[i].ctl;
      kernel_in   = tbl[i].kin;
      sample_in   = W'(tbl[i].s);
      conv_result = (2*W)'(tbl[i].r);
      @(posedge clk);
      #1;
      check($sformatf("row%0d sample_ready", i), DW'(sample_ready), DW'(tbl[i].exp[3]));
      check($sformatf("row%0d conv_valid", i), DW'(conv_valid), DW'(tbl[i].exp[2]));
      check($sformatf("row%0d conv_result_ready", i), DW'(conv_result_ready), DW'(tbl[i].exp[1]));
      check($sformatf("row%0d result_valid", i), DW'(result_valid), DW'(tbl[i].exp[0]));
      check($sformatf("row%0d windows_issued", i), DW'(windows_issued), DW'(tbl[i].wi));
      check($sformatf("row%0d conv_data", i), conv_data, tbl[i].data);
      check($sformatf("row%0d conv_kernel", i), conv_kernel, tbl[i].kern);
      check($sformatf("row%0d result_out", i), DW'(result_out), DW'(tbl[i].res));
    end

    // Reset asserted mid-cycle while a window is outstanding in WAIT.
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("midrst conv_valid", DW'(conv_valid), DW'(0));
    check("midrst conv_result_ready", DW'(conv_result_ready), DW'(0));
    check("midrst result_valid", DW'(result_valid), DW'(0));
    check("midrst sample_ready", DW'(sample_ready), DW'(1));
    check("midrst windows_issued", DW'(windows_issued), DW'(0));
    check("midrst conv_data", conv_data, zz);
    check("midrst conv_kernel", conv_kernel, zz);
    check("midrst result_out", DW'(result_out), DW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    conv_result_valid = 1'b1;
    conv_result = (2*W)'(123);
    @(posedge clk);
    #1;
    check("late result_valid", DW'(result_valid), DW'(0));
    check("late conv_result_ready", DW'(conv_result_ready), DW'(0));
    check("late sample_ready", DW'(sample_ready), DW'(1));
    check("late windows_issued", DW'(windows_issued), DW'(0));
    check("late result_out", DW'(result_out), DW'(0));
    idle_inputs();

    // Randomized traffic against the reference model, starting from a clean reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < NRND; c++) begin
      rst               = ($urandom_range(99) == 0);
      kernel_load       = ($urandom_range(9) == 0);
      flush             = ($urandom_range(19) == 0);
      sample_valid      = ($urandom_range(9) < 6);
      conv_ready        = $urandom_range(1) == 1;
      conv_result_valid = $urandom_range(1) == 1;
      result_ready      = $urandom_range(1) == 1;
      sample_in         = {$urandom(), $urandom()};
      conv_result       = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int i = 0; i < 2 * L; i++) kernel_in[i*32 +: 32] = $urandom();
      model_edge();
      @(posedge clk);
      #1;
      cmp_model(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
